pcileech_com_tx_unpack: RTL

//  Width down-converter on the host-bound path, on the FT601 side of the FIFO.

---
 rtl/pcileech_com_tx_unpack.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pcileech_com_tx_unpack.sv
// pcileech_com_tx_unpack: splits 256-bit masked beats into a 32-bit dword stream.
// A cur/nxt beat buffer feeds one output register; only masked-in dwords leave.
module pcileech_com_tx_unpack #(
   parameter int PARAM_CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [255:0]               din,
   input  logic [7:0]                 din_mask,
   input  logic                       din_valid,
   output logic                       din_ready,
   output logic [31:0]                dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       busy,
   output logic [PARAM_CNT_WIDTH-1:0] dword_count
);

   localparam logic [PARAM_CNT_WIDTH-1:0] CNT_ONE = 1;

   logic [255:0]               cur_data;
   logic [7:0]                 cur_mask;
   logic [255:0]               nxt_data;
   logic [7:0]                 nxt_mask;
   logic                       nxt_full;
   logic [31:0]                out_data;
   logic                       out_valid;
   logic                       ready_q;
   logic [PARAM_CNT_WIDTH-1:0] cnt_q;

   logic [255:0] cur_data_n;
   logic [7:0]   cur_mask_n;
   logic [255:0] nxt_data_n;
   logic [7:0]   nxt_mask_n;
   logic         nxt_full_n;

   logic         accept;
   logic         consume;
   logic         out_load;
   logic         take;
   logic         din_live;
   logic         cur_done;
   logic [2:0]   sel;
   logic [7:0]   sel_bit;
   logic [7:0]   cur_rem;
   logic [31:0]  sel_dword;

   // lowest set bit of the remaining mask picks the next dword
   always_comb begin
      sel = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (cur_mask[i]) sel = 3'(i);
      end
   end

   assign sel_bit   = 8'b1 << sel;
   assign sel_dword = cur_data[{sel, 5'd0} +: 32];

   assign accept   = din_valid & ready_q;
   assign consume  = out_valid & dout_ready;
   assign out_load = ~out_valid | dout_ready;
   assign take     = out_load & (cur_mask != 8'd0);
   assign cur_rem  = take ? (cur_mask & ~sel_bit) : cur_mask;
   assign cur_done = (cur_rem == 8'd0);
   // empty-mask beats complete the handshake but are never stored
   assign din_live = accept & (din_mask != 8'd0);

   // cur empty implies nxt empty, so a new beat goes to cur whenever cur drains
   always_comb begin
      cur_data_n = cur_data;
      cur_mask_n = cur_rem;
      nxt_data_n = nxt_data;
      nxt_mask_n = nxt_mask;
      nxt_full_n = nxt_full;
      if (cur_done && nxt_full) begin
         cur_data_n = nxt_data;
         cur_mask_n = nxt_mask;
         nxt_full_n = 1'b0;
      end else if (cur_done && din_live) begin
         cur_data_n = din;
         cur_mask_n = din_mask;
      end else if (din_live) begin
         nxt_data_n = din;
         nxt_mask_n = din_mask;
         nxt_full_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_data  <= '0;
         cur_mask  <= '0;
         nxt_data  <= '0;
         nxt_mask  <= '0;
         nxt_full  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         ready_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         cur_data <= cur_data_n;
         cur_mask <= cur_mask_n;
         nxt_data <= nxt_data_n;
         nxt_mask <= nxt_mask_n;
         nxt_full <= nxt_full_n;
         ready_q  <= ~nxt_full_n;
         if (out_load) begin
            out_valid <= take;
            if (take) out_data <= sel_dword;
         end
         if (consume) cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign din_ready   = ready_q;
   assign dout        = out_data;
   assign dout_valid  = out_valid;
   assign busy        = out_valid | (cur_mask != 8'd0) | nxt_full;
   assign dword_count = cnt_q;

endmodule
